// File: rtl/microarch_defs.sv
// Shared SAP-1.5 micro-architecture definitions: opcodes, control word layout
// and the micro-step encoding used by the control sequencer.
package microarch_defs;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // MSB first: halt is bit 15, out_load is bit 0.
  typedef struct packed {
    logic halt;
    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out;
    logic ram_write;
    logic ir_load;
    logic oprnd_out;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_out;
    logic alu_sub;
    logic flags_load;
    logic out_load;
  } control_word_t;

  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_HALT = 3'd5
  } ustep_e;

endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// Combinational microcode: (opcode, micro-step, flags) -> control word and
// a marker for the last micro-step of the instruction.
module microcode_rom
  import microarch_defs::*;
#(
  parameter int unsigned HALT_ON_ILLEGAL = 0
) (
  input  logic [3:0]    opcode,
  input  ustep_e        step,
  input  logic          carry,
  input  logic          zero,
  output control_word_t cw,
  output logic          last_step
);

  opcode_e op;
  assign op = opcode_e'(opcode);

  always_comb begin
    cw        = '0;
    last_step = 1'b0;
    case (step)
      S_T0: begin
        cw.pc_out   = 1'b1;
        cw.mar_load = 1'b1;
      end
      S_T1: begin
        cw.ram_out = 1'b1;
        cw.ir_load = 1'b1;
        cw.pc_inc  = 1'b1;
      end
      S_T2: begin
        case (op)
          OP_NOP: last_step = 1'b1;
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw.oprnd_out = 1'b1;
            cw.mar_load  = 1'b1;
          end
          OP_LDI: begin
            cw.oprnd_out = 1'b1;
            cw.a_load    = 1'b1;
            last_step    = 1'b1;
          end
          OP_JMP: begin
            cw.oprnd_out = 1'b1;
            cw.pc_load   = 1'b1;
            last_step    = 1'b1;
          end
          OP_JC: begin
            cw.oprnd_out = carry;
            cw.pc_load   = carry;
            last_step    = 1'b1;
          end
          OP_JZ: begin
            cw.oprnd_out = zero;
            cw.pc_load   = zero;
            last_step    = 1'b1;
          end
          OP_OUT: begin
            cw.a_out    = 1'b1;
            cw.out_load = 1'b1;
            last_step   = 1'b1;
          end
          OP_HLT: begin
            cw.halt   = 1'b1;
            last_step = 1'b1;
          end
          default: begin
            // Undefined opcodes: NOP, or halt when configured to trap them.
            cw.halt   = (HALT_ON_ILLEGAL != 0);
            last_step = 1'b1;
          end
        endcase
      end
      S_T3: begin
        case (op)
          OP_LDA: begin
            cw.ram_out = 1'b1;
            cw.a_load  = 1'b1;
            last_step  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw.ram_out = 1'b1;
            cw.b_load  = 1'b1;
          end
          OP_STA: begin
            cw.a_out     = 1'b1;
            cw.ram_write = 1'b1;
            last_step    = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      S_T4: begin
        cw.alu_out    = 1'b1;
        cw.a_load     = 1'b1;
        cw.flags_load = 1'b1;
        cw.alu_sub    = (op == OP_SUB);
        last_step     = 1'b1;
      end
      S_HALT: cw.halt = 1'b1;
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// SAP-1.5 control sequencer: step/halt state machine around the microcode ROM.
// All outputs are forced low while reset is held, independent of the clock.
module control_sequencer
  import microarch_defs::*;
#(
  parameter int unsigned HALT_ON_ILLEGAL = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    opcode,
  input  logic          flag_carry,
  input  logic          flag_zero,
  output control_word_t control_word,
  output logic [2:0]    step,
  output logic          instr_done,
  output logic          halted
);

  ustep_e        state;
  ustep_e        state_next;
  control_word_t rom_cw;
  logic          rom_last;

  microcode_rom #(
    .HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)
  ) u_rom (
    .opcode    (opcode),
    .step      (state),
    .carry     (flag_carry),
    .zero      (flag_zero),
    .cw        (rom_cw),
    .last_step (rom_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_T0;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_HALT: state_next = S_HALT;
      default: begin
        if (rom_last) state_next = rom_cw.halt ? S_HALT : S_T0;
        else          state_next = ustep_e'(3'(state) + 3'd1);
      end
    endcase
  end

  assign control_word = reset ? rom_cw : '0;
  assign halted       = reset && (state == S_HALT);
  assign instr_done   = reset && (state != S_HALT) && rom_last;
  assign step         = (reset && state != S_HALT) ? 3'(state) : 3'd0;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-instruction control word sequences,
// flag-dependent jumps, halting, asynchronous reset and illegal-opcode handling.
module tb_control_sequencer;

  localparam logic [15:0] HALT       = 16'h8000;
  localparam logic [15:0] PC_OUT     = 16'h4000;
  localparam logic [15:0] PC_INC     = 16'h2000;
  localparam logic [15:0] PC_LOAD    = 16'h1000;
  localparam logic [15:0] MAR_LOAD   = 16'h0800;
  localparam logic [15:0] RAM_OUT    = 16'h0400;
  localparam logic [15:0] RAM_WRITE  = 16'h0200;
  localparam logic [15:0] IR_LOAD    = 16'h0100;
  localparam logic [15:0] OPRND_OUT  = 16'h0080;
  localparam logic [15:0] A_LOAD     = 16'h0040;
  localparam logic [15:0] A_OUT      = 16'h0020;
  localparam logic [15:0] B_LOAD     = 16'h0010;
  localparam logic [15:0] ALU_OUT    = 16'h0008;
  localparam logic [15:0] ALU_SUB    = 16'h0004;
  localparam logic [15:0] FLAGS_LOAD = 16'h0002;
  localparam logic [15:0] OUT_LOAD   = 16'h0001;
  localparam logic [15:0] FETCH0     = PC_OUT | MAR_LOAD;
  localparam logic [15:0] FETCH1     = RAM_OUT | IR_LOAD | PC_INC;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic        flag_carry;
  logic        flag_zero;
  logic [15:0] cw0, cw1;
  logic [2:0]  step0, step1;
  logic        done0, done1;
  logic        halted0, halted1;

  int tests_run = 0;
  int errors    = 0;
  logic [15:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  control_sequencer #(.HALT_ON_ILLEGAL(0)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .flag_carry   (flag_carry),
    .flag_zero    (flag_zero),
    .control_word (cw0),
    .step         (step0),
    .instr_done   (done0),
    .halted       (halted0)
  );

  control_sequencer #(.HALT_ON_ILLEGAL(1)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .flag_carry   (flag_carry),
    .flag_zero    (flag_zero),
    .control_word (cw1),
    .step         (step1),
    .instr_done   (done1),
    .halted       (halted1)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // driver: runs one instruction, checking each step against the queued words
  task automatic run_instr(input string tag, input logic [3:0] op, input logic c,
                           input logic z, input int first_step);
    int n;
    logic [15:0] exp;
    opcode     = op;
    flag_carry = c;
    flag_zero  = z;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      #1;
      exp = exp_q.pop_front();
      check($sformatf("%s cw T%0d", tag, i + first_step), cw0, exp);
      check($sformatf("%s step T%0d", tag, i + first_step), 16'(step0), 16'(i + first_step));
      check($sformatf("%s done T%0d", tag, i + first_step), 16'(done0), 16'(i == n - 1));
      check($sformatf("%s halted T%0d", tag, i + first_step), 16'(halted0), 16'h0);
      tick();
    end
  endtask

  task automatic push_fetch();
    exp_q.push_back(FETCH0);
    exp_q.push_back(FETCH1);
  endtask

  initial begin
    reset      = 1'b0;
    opcode     = 4'h1;
    flag_carry = 1'b0;
    flag_zero  = 1'b0;
    #7;
    check("rst cw", cw0, 16'h0);
    check("rst step", 16'(step0), 16'h0);
    check("rst done", 16'(done0), 16'h0);
    check("rst halted", 16'(halted0), 16'h0);
    tick();
    tick();
    reset = 1'b1;

    push_fetch();
    exp_q.push_back(OPRND_OUT | MAR_LOAD);
    exp_q.push_back(RAM_OUT | A_LOAD);
    run_instr("LDA", 4'h1, 1'b0, 1'b0, 0);

    push_fetch();
    exp_q.push_back(OPRND_OUT | MAR_LOAD);
    exp_q.push_back(RAM_OUT | B_LOAD);
    exp_q.push_back(ALU_OUT | A_LOAD | FLAGS_LOAD | ALU_SUB);
    run_instr("SUB", 4'h3, 1'b1, 1'b1, 0);

    push_fetch();
    exp_q.push_back(OPRND_OUT | MAR_LOAD);
    exp_q.push_back(RAM_OUT | B_LOAD);
    exp_q.push_back(ALU_OUT | A_LOAD | FLAGS_LOAD);
    run_instr("ADD", 4'h2, 1'b0, 1'b0, 0);

    push_fetch();
    exp_q.push_back(OPRND_OUT | MAR_LOAD);
    exp_q.push_back(A_OUT | RAM_WRITE);
    run_instr("STA", 4'h4, 1'b0, 1'b0, 0);

    push_fetch();
    exp_q.push_back(OPRND_OUT | A_LOAD);
    run_instr("LDI", 4'h5, 1'b0, 1'b0, 0);

    push_fetch();
    exp_q.push_back(OPRND_OUT | PC_LOAD);
    run_instr("JMP", 4'h6, 1'b0, 1'b0, 0);

    push_fetch();
    exp_q.push_back(16'h0);
    run_instr("JC c0", 4'h7, 1'b0, 1'b1, 0);

    push_fetch();
    exp_q.push_back(OPRND_OUT | PC_LOAD);
    run_instr("JC c1", 4'h7, 1'b1, 1'b0, 0);

    push_fetch();
    exp_q.push_back(OPRND_OUT | PC_LOAD);
    run_instr("JZ z1", 4'h8, 1'b0, 1'b1, 0);

    push_fetch();
    exp_q.push_back(16'h0);
    run_instr("JZ z0", 4'h8, 1'b1, 1'b0, 0);

    push_fetch();
    exp_q.push_back(A_OUT | OUT_LOAD);
    run_instr("OUT", 4'hE, 1'b0, 1'b0, 0);

    push_fetch();
    exp_q.push_back(16'h0);
    run_instr("NOP", 4'h0, 1'b0, 1'b0, 0);

    // asynchronous reset during T3 of ADD
    opcode = 4'h2;
    tick();
    tick();
    tick();
    #1;
    check("ADD pre-rst cw", cw0, RAM_OUT | B_LOAD);
    check("ADD pre-rst step", 16'(step0), 16'h3);
    #1 reset = 1'b0;
    #1;
    check("mid rst cw", cw0, 16'h0);
    check("mid rst step", 16'(step0), 16'h0);
    #1 reset = 1'b1;
    #1;
    check("post rst cw", cw0, FETCH0);
    check("post rst step", 16'(step0), 16'h0);
    tick();
    exp_q.push_back(FETCH1);
    exp_q.push_back(OPRND_OUT | MAR_LOAD);
    exp_q.push_back(RAM_OUT | B_LOAD);
    exp_q.push_back(ALU_OUT | A_LOAD | FLAGS_LOAD);
    run_instr("ADD restart", 4'h2, 1'b0, 1'b0, 1);

    push_fetch();
    exp_q.push_back(HALT);
    run_instr("HLT", 4'hF, 1'b0, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      opcode = 4'(i);
      #1;
      check("HALT halted", 16'(halted0), 16'h1);
      check("HALT cw", cw0, HALT);
      check("HALT step", 16'(step0), 16'h0);
      check("HALT done", 16'(done0), 16'h0);
      tick();
    end
    reset = 1'b0;
    #1;
    check("HALT rst halted", 16'(halted0), 16'h0);
    check("HALT rst cw", cw0, 16'h0);
    #1 reset = 1'b1;

    // illegal opcode: NOP on dut0, trap on dut1
    opcode = 4'hA;
    tick();
    tick();
    #1;
    check("ILL1 T2 cw", cw1, HALT);
    check("ILL1 T2 done", 16'(done1), 16'h1);
    check("ILL1 T2 halted", 16'(halted1), 16'h0);
    check("ILL0 T2 cw", cw0, 16'h0);
    check("ILL0 T2 done", 16'(done0), 16'h1);
    tick();
    #1;
    check("ILL1 halted", 16'(halted1), 16'h1);
    check("ILL1 halt cw", cw1, HALT);
    check("ILL0 wrap step", 16'(step0), 16'h0);
    check("ILL0 wrap cw", cw0, FETCH0);
    check("ILL0 halted", 16'(halted0), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, errors);
    $finish;
  end

endmodule
